clk_div_bank: RTL and testbench

- Multi-channel, runtime-programmable clock divider for game-logic timing (frame tick, animation tick, debounce sample, etc.).
- Each channel produces a registered square wave and a one-cycle tick from one fabric clock.
- Each channel supports a manual single-step mode driven by a push-button.
- Replaces fixed-division single-channel dividers; all channels share one clock domain, and outputs are used as clock enables, never as clocks.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_channel.sv | 87 ++++++++
 rtl/clk_div_bank.sv | 38 +++
 tb/tb_clk_div_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock-divider bank.
// Divisor words are handled at MAX_W bits inside the helpers; W must not exceed MAX_W.
package clk_div_pkg;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned DEFAULT_W = 32;
  localparam int unsigned MAX_W     = 64;

  typedef logic [MAX_W-1:0] div_word_t;

  // Divisors below DIV_MIN would give a stuck or zero-length period.
  function automatic div_word_t div_clamp(input div_word_t v);
    return (v < div_word_t'(DIV_MIN)) ? div_word_t'(DIV_MIN) : v;
  endfunction

  // High phase length; odd divisors get the extra cycle in the high phase.
  function automatic div_word_t hi_len(input div_word_t d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, registered square wave and tick, plus a
// manual-step path fed by a 2-flop synchroniser with edge detect.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned W           = DEFAULT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [W-1:0] div_value,
  input  logic         div_load,
  input  logic         sync_all,
  input  logic         bypass,
  input  logic         step,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] One    = W'(1);
  localparam logic [W-1:0] RstDiv = W'(div_clamp(div_word_t'(DEFAULT_DIV)));

  logic [W-1:0] div_q, div_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_nxt, hi;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic         s1_q, s2_q, s3_q;
  logic         bypass_q;
  logic         restart;

  always_comb begin
    div_d = div_q;
    if (div_load) begin
      div_d = W'(div_clamp(div_word_t'(div_value)));
    end

    // Loads while in bypass only update the divisor; the exit restart picks it up.
    restart = ~bypass & (div_load | sync_all | bypass_q);

    hi      = W'(hi_len(div_word_t'(div_q)));
    cnt_nxt = (cnt_q == div_q - One) ? '0 : cnt_q + One;

    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;

    if (restart) begin
      cnt_d     = div_d - One;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end else if (bypass) begin
      clk_out_d = s2_q;
      tick_d    = s2_q & ~s3_q;
    end else begin
      cnt_d     = cnt_nxt;
      clk_out_d = (cnt_nxt < hi);
      tick_d    = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      div_q     <= RstDiv;
      cnt_q     <= RstDiv - One;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      bypass_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      s1_q      <= step;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      bypass_q  <= bypass;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable dividers sharing one clock,
// reset and sync_all; outputs are clock enables, not clocks.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned W           = DEFAULT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [CHANNELS*W-1:0] div_value,
  input  logic [CHANNELS-1:0]   div_load,
  input  logic                  sync_all,
  input  logic [CHANNELS-1:0]   bypass,
  input  logic [CHANNELS-1:0]   step,
  output logic [CHANNELS-1:0]   clk_out,
  output logic [CHANNELS-1:0]   tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clk_div_channel #(
      .W          (W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .reset    (reset),
      .div_value(div_value[i*W +: W]),
      .div_load (div_load[i]),
      .sync_all (sync_all),
      .bypass   (bypass[i]),
      .step     (step[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: vector table for run/load/sync behaviour,
// hand-written sequences for bypass stepping, load-in-bypass and mid-period reset.
module tb_clk_div_bank;

  logic        clk_in;
  logic        reset;
  logic [63:0] div_value;
  logic [1:0]  div_load;
  logic        sync_all;
  logic [1:0]  bypass;
  logic [1:0]  step;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  int n_total = 0;
  int n_pass  = 0;

  clk_div_bank #(
    .CHANNELS   (2),
    .W          (32),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .div_value(div_value),
    .div_load (div_load),
    .sync_all (sync_all),
    .bypass   (bypass),
    .step     (step),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst_n;
    logic [1:0]  load;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        sync;
    logic [1:0]  exp_clk;
    logic [1:0]  exp_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] ld, input logic [31:0] d0,
                              input logic [31:0] d1, input logic sy, input logic [1:0] ec,
                              input logic [1:0] et);
    vec_t v;
    v.rst_n = r; v.load = ld; v.d0 = d0; v.d1 = d1; v.sync = sy;
    v.exp_clk = ec; v.exp_tick = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic edge_wait();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [0:6] ec_e;
    logic [0:6] et_e;
    logic [0:5] ec_f1;
    logic [0:5] et_f1;
    logic [0:9] ec_f2;
    logic [0:9] et_f2;

    reset = 1'b0; div_value = '0; div_load = '0; sync_all = 1'b0; bypass = '0; step = '0;

    // Reset held 3 cycles, then divide-by-2 default
    repeat (3) vecs.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    // ch0 div 4, ch1 div 3 loaded together
    vecs.push_back(mk(1, 2'b11, 4, 3, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b01));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b01, 2'b01));
    // Clamp: div 0 then div 1 both behave as div 2
    vecs.push_back(mk(1, 2'b11, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b11, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00));
    // ch0 div 5, ch1 div 7, then sync_all mid-period
    vecs.push_back(mk(1, 2'b11, 5, 7, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b11));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b11, 2'b00));

    foreach (vecs[k]) begin
      reset     = vecs[k].rst_n;
      div_load  = vecs[k].load;
      div_value = {vecs[k].d1, vecs[k].d0};
      sync_all  = vecs[k].sync;
      edge_wait();
      check($sformatf("vec%0d_clk", k), clk_out, vecs[k].exp_clk);
      check($sformatf("vec%0d_tick", k), tick, vecs[k].exp_tick);
    end
    div_load = '0; sync_all = 1'b0; div_value = '0;

    // ch0 bypass: step pressed before E1, held for 10 edges, then released
    bypass = 2'b01;
    step   = 2'b01;
    for (int e = 1; e <= 13; e++) begin
      if (e == 11) step = 2'b00;
      edge_wait();
      check($sformatf("byp_clk_e%0d", e), {1'b0, clk_out[0]}, {1'b0, (e >= 3 && e <= 12)});
      check($sformatf("byp_tick_e%0d", e), {1'b0, tick[0]}, {1'b0, (e == 3)});
    end

    // Bypass exit restarts ch0 at its divisor of 5
    bypass = 2'b00;
    ec_e = 7'b0111001;
    et_e = 7'b0100001;
    for (int e = 0; e < 7; e++) begin
      edge_wait();
      check($sformatf("bexit_clk_%0d", e), {1'b0, clk_out[0]}, {1'b0, ec_e[e]});
      check($sformatf("bexit_tick_%0d", e), {1'b0, tick[0]}, {1'b0, et_e[e]});
    end

    // Load div 6 while in bypass with button held: outputs stay under bypass control
    bypass = 2'b01;
    step   = 2'b01;
    ec_f1 = 6'b001111;
    et_f1 = 6'b001000;
    for (int e = 0; e < 6; e++) begin
      if (e == 4) begin
        div_load  = 2'b01;
        div_value = {32'd0, 32'd6};
      end else begin
        div_load = 2'b00;
      end
      edge_wait();
      check($sformatf("bload_clk_%0d", e), {1'b0, clk_out[0]}, {1'b0, ec_f1[e]});
      check($sformatf("bload_tick_%0d", e), {1'b0, tick[0]}, {1'b0, et_f1[e]});
    end
    div_load = 2'b00;

    // Exit bypass: div 6 gives 111000
    bypass = 2'b00;
    ec_f2 = 10'b0111000111;
    et_f2 = 10'b0100000100;
    for (int e = 0; e < 10; e++) begin
      edge_wait();
      check($sformatf("div6_clk_%0d", e), {1'b0, clk_out[0]}, {1'b0, ec_f2[e]});
      check($sformatf("div6_tick_%0d", e), {1'b0, tick[0]}, {1'b0, et_f2[e]});
    end
    step = 2'b00;

    // Reset at cnt=2 of div 6: outputs drop, divisor reverts to 2
    reset = 1'b0;
    edge_wait();
    check("mreset_clk", clk_out, 2'b00);
    check("mreset_tick", tick, 2'b00);
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      edge_wait();
      check($sformatf("post_rst_clk_%0d", e), clk_out, (e % 2 == 0) ? 2'b11 : 2'b00);
      check($sformatf("post_rst_tick_%0d", e), tick, (e % 2 == 0) ? 2'b11 : 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
